// File: rtl/redun_norm_if.sv
// Handshake/result bundle between the redundant-form squarer and redun_norm.
// master: producer of redundant words and consumer of the result; slave: redun_norm.
interface redun_norm_if #(
    parameter int unsigned NUM_WRDS = 4,
    parameter int unsigned WRD_BITS = 16
);
    logic [NUM_WRDS-1:0][WRD_BITS:0]  i_dat;   // word 0 least significant, top bit is carry
    logic                             i_val;
    logic                             o_rdy;
    logic [NUM_WRDS*WRD_BITS-1:0]     o_dat;
    logic [1:0]                       o_carry;
    logic                             o_val;
    logic                             o_drop;

    modport master (
        output i_dat, i_val,
        input  o_rdy, o_dat, o_carry, o_val, o_drop
    );

    modport slave (
        input  i_dat, i_val,
        output o_rdy, o_dat, o_carry, o_val, o_drop
    );
endinterface

// File: rtl/redun_norm.sv
// redun_norm: resolves redundant carry-save words into plain binary, one word per cycle,
// so the carry path stays a single WRD_BITS+2-bit adder.
// Optional feature macro: REDUN_NORM_FINAL_SUB_EN adds one word-serial conditional
// subtraction of MOD before the result is presented. Without it MOD is unused.
// Defaults mirror the squarer package values (4 x 16-bit words).
module redun_norm #(
    parameter int unsigned                      NUM_WRDS = 4,
    parameter int unsigned                      WRD_BITS = 16,
    parameter logic [NUM_WRDS*WRD_BITS-1:0]     MOD      = 64'h8000_0000_0000_0001
) (
    input  logic         i_clk,
    input  logic         i_rst,
    redun_norm_if.slave  io_bus
);
    localparam int unsigned IdxW = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;

    typedef enum logic [1:0] {StIdle, StProp, StSub, StDone} state_e;

    state_e                             r_state;
    logic [NUM_WRDS-1:0][WRD_BITS:0]    r_hold;
    logic [NUM_WRDS-1:0][WRD_BITS-1:0]  r_out;
    logic [1:0]                         r_c;
    logic [IdxW-1:0]                    r_idx;

    logic [WRD_BITS:0]                  w_word;
    logic [WRD_BITS:0]                  w_sum;
    logic [1:0]                         w_c_next;
    logic                               w_last;

    // Carry-resolve datapath for the current word
    always_comb begin
        w_word   = r_hold[r_idx];
        w_sum    = {1'b0, w_word[WRD_BITS-1:0]} + {{(WRD_BITS-1){1'b0}}, r_c};
        w_c_next = {1'b0, w_word[WRD_BITS]} + {1'b0, w_sum[WRD_BITS]};
        w_last   = (r_idx == IdxW'(NUM_WRDS - 1));
    end

`ifdef REDUN_NORM_FINAL_SUB_EN
    localparam logic [NUM_WRDS-1:0][WRD_BITS-1:0] ModWrds = MOD;

    logic [NUM_WRDS-1:0][WRD_BITS-1:0]  r_scr;
    logic                               r_bw;
    logic [NUM_WRDS-1:0][WRD_BITS-1:0]  w_scr;
    logic [WRD_BITS:0]                  w_diff;
    logic [1:0]                         w_top;
    logic                               w_top_bw;

    // Borrow-serial subtract of one MOD word; top limb is the resolved carry
    always_comb begin
        w_diff        = {1'b0, r_out[r_idx]} - {1'b0, ModWrds[r_idx]}
                        - {{WRD_BITS{1'b0}}, r_bw};
        w_scr         = r_scr;
        w_scr[r_idx]  = w_diff[WRD_BITS-1:0];
        w_top         = r_c - {1'b0, w_diff[WRD_BITS]};
        w_top_bw      = (r_c == 2'd0) && w_diff[WRD_BITS];
    end
`endif

    // Control FSM with registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_hold         <= '0;
            r_out          <= '0;
            r_c            <= 2'd0;
            r_idx          <= '0;
            io_bus.o_rdy   <= 1'b1;
            io_bus.o_dat   <= '0;
            io_bus.o_carry <= 2'd0;
            io_bus.o_val   <= 1'b0;
            io_bus.o_drop  <= 1'b0;
`ifdef REDUN_NORM_FINAL_SUB_EN
            r_scr          <= '0;
            r_bw           <= 1'b0;
`endif
        end else begin
            io_bus.o_val  <= 1'b0;
            io_bus.o_drop <= io_bus.i_val && (r_state != StIdle);
            case (r_state)
                StIdle: begin
                    if (io_bus.i_val) begin
                        r_hold       <= io_bus.i_dat;
                        r_c          <= 2'd0;
                        r_idx        <= '0;
                        io_bus.o_rdy <= 1'b0;
                        r_state      <= StProp;
                    end else begin
                        // Ready rises one cycle after o_val, once IDLE is settled
                        io_bus.o_rdy <= 1'b1;
                    end
                end
                StProp: begin
                    r_out[r_idx] <= w_sum[WRD_BITS-1:0];
                    r_c          <= w_c_next;
                    if (w_last) begin
                        r_idx   <= '0;
`ifdef REDUN_NORM_FINAL_SUB_EN
                        r_bw    <= 1'b0;
                        r_state <= StSub;
`else
                        r_state <= StDone;
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
`ifdef REDUN_NORM_FINAL_SUB_EN
                StSub: begin
                    r_scr <= w_scr;
                    r_bw  <= w_diff[WRD_BITS];
                    if (w_last) begin
                        // Commit only when {c, out} >= MOD
                        if (!w_top_bw) begin
                            r_out <= w_scr;
                            r_c   <= w_top;
                        end
                        r_idx   <= '0;
                        r_state <= StDone;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
`endif
                StDone: begin
                    io_bus.o_dat   <= r_out;
                    io_bus.o_carry <= r_c;
                    io_bus.o_val   <= 1'b1;
                    r_state        <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_redun_norm.sv
// Directed bench for redun_norm (4 x 16-bit words). Build with REDUN_NORM_FINAL_SUB_EN
// defined to exercise the final-subtract variant.
module tb_redun_norm;
    localparam int unsigned NW = 4;
    localparam int unsigned WB = 16;
    localparam logic [63:0] MODV = 64'h8000_0000_0000_0001;
`ifdef REDUN_NORM_FINAL_SUB_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_errs   = 0;

    redun_norm_if #(.NUM_WRDS(NW), .WRD_BITS(WB)) bus ();

    redun_norm #(.NUM_WRDS(NW), .WRD_BITS(WB), .MOD(MODV)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NW-1:0][WB:0] mk(input logic [WB:0] w0, input logic [WB:0] w1,
                                               input logic [WB:0] w2, input logic [WB:0] w3);
        logic [NW-1:0][WB:0] d;
        d[0] = w0; d[1] = w1; d[2] = w2; d[3] = w3;
        return d;
    endfunction

    // Reference: plain sum of weighted redundant words, optionally reduced once
    function automatic logic [65:0] model(input logic [NW-1:0][WB:0] d);
        logic [65:0] r;
        r = '0;
        for (int k = 0; k < NW; k++) r = r + (66'(d[k]) << (WB * k));
`ifdef REDUN_NORM_FINAL_SUB_EN
        if (r >= {2'b00, MODV}) r = r - {2'b00, MODV};
`endif
        return r;
    endfunction

    task automatic run_one(input logic [NW-1:0][WB:0] d, output logic [65:0] res,
                           output int lat, output logic seen);
        int cap;
        @(negedge clk);
        bus.i_dat = d;
        bus.i_val = 1'b1;
        cap = edge_cnt + 1;
        @(negedge clk);
        bus.i_val = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.o_val) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        res = {bus.o_carry, bus.o_dat};
        lat = edge_cnt - cap;
    endtask

    logic [NW-1:0][WB:0] d;
    logic [65:0]         res;
    int                  lat;
    logic                seen;
    logic [65:0]         exp_max;
    logic [65:0]         exp_rst;

    initial begin
        bus.i_dat = '0;
        bus.i_val = 1'b0;
`ifdef REDUN_NORM_FINAL_SUB_EN
        exp_max = 66'h1_8001_0001_0000_FFFE;
        exp_rst = 66'h0_7FFF_0000_0001_FFFE;
`else
        exp_max = 66'h2_0001_0001_0000_FFFF;
        exp_rst = 66'h0_FFFF_0000_0001_FFFF;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy",   66'(bus.o_rdy), 66'd1);
        check("rst_val",   66'(bus.o_val), 66'd0);
        check("rst_drop",  66'(bus.o_drop), 66'd0);
        check("rst_res",   {bus.o_carry, bus.o_dat}, 66'd0);

        // Basic
        run_one(mk(17'h10005, 17'h0, 17'h0, 17'h0), res, lat, seen);
        check("basic_seen", 66'(seen), 66'd1);
        check("basic_res",  res, 66'h0_0000_0000_0001_0005);
        check("basic_lat",  66'(lat), 66'(LAT));

        // Max carry
        d = mk(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
        run_one(d, res, lat, seen);
        check("max_seen",  66'(seen), 66'd1);
        check("max_res",   res, exp_max);
        check("max_model", res, model(d));

`ifdef REDUN_NORM_FINAL_SUB_EN
        run_one(mk(17'h00001, 17'h0, 17'h0, 17'h08000), res, lat, seen);
        check("sub_eq_mod", res, 66'd0);
        check("sub_lat",    66'(lat), 66'd9);
        run_one(mk(17'h0, 17'h0, 17'h0, 17'h08000), res, lat, seen);
        check("sub_mod_m1", res, 66'h0_8000_0000_0000_0000);
        // 2*MOD-1 = 2^64+1, one subtraction leaves MOD-1
        run_one(mk(17'h00001, 17'h0, 17'h0, 17'h10000), res, lat, seen);
        check("sub_2mod_m1", res, 66'h0_8000_0000_0000_0000);
`endif

        // Busy drop: second strobe two cycles after capture
        begin
            int   n_val;
            int   n_drop;
            logic rdy_hi;
            logic done;
            n_val = 0; n_drop = 0; rdy_hi = 1'b0; done = 1'b0;
            @(negedge clk);
            bus.i_dat = mk(17'h00123, 17'h1ABCD, 17'h0, 17'h0);
            bus.i_val = 1'b1;
            @(negedge clk);
            bus.i_val = 1'b0;
            if (bus.o_rdy) rdy_hi = 1'b1;
            @(negedge clk);
            bus.i_dat = mk(17'h1, 17'h1, 17'h1, 17'h1);
            bus.i_val = 1'b1;
            if (bus.o_rdy) rdy_hi = 1'b1;
            @(negedge clk);
            bus.i_val = 1'b0;
            for (int n = 0; n < 25; n++) begin
                if (!done && bus.o_rdy) rdy_hi = 1'b1;
                if (bus.o_drop) n_drop++;
                if (bus.o_val) begin
                    n_val++;
                    done = 1'b1;
                    res  = {bus.o_carry, bus.o_dat};
                end
                @(negedge clk);
            end
            check("busy_drop_cnt", 66'(n_drop), 66'd1);
            check("busy_val_cnt",  66'(n_val), 66'd1);
            check("busy_rdy_low",  66'(rdy_hi), 66'd0);
            check("busy_res",      res, 66'h0_0000_0001_ABCD_0123);
            check("busy_rdy_back", 66'(bus.o_rdy), 66'd1);
        end

        // Reset mid-PROP
        @(negedge clk);
        bus.i_dat = mk(17'h1FFFF, 17'h0, 17'h0, 17'h0FFFF);
        bus.i_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_val = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_rdy", 66'(bus.o_rdy), 66'd1);
        check("midrst_res", {bus.o_carry, bus.o_dat}, 66'd0);
        check("midrst_val", 66'(bus.o_val), 66'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 15; n++) begin
            if (bus.o_val) seen = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_val", 66'(seen), 66'd0);
        d = mk(17'h1FFFF, 17'h0, 17'h0, 17'h0FFFF);
        run_one(d, res, lat, seen);
        check("postrst_res", res, exp_rst);
        check("postrst_lat", 66'(lat), 66'(LAT));

        // Back-to-back random
        begin
            int   n_drop;
            int   n_bad;
            int   n_miss;
            logic [NW-1:0][WB:0] cur;
            n_drop = 0; n_bad = 0; n_miss = 0;
            for (int k = 0; k < NW; k++) cur[k] = 17'($urandom & 32'h1FFFF);
            @(negedge clk);
            bus.i_dat = cur;
            bus.i_val = 1'b1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                bus.i_val = 1'b0;
                seen = 1'b0;
                for (int n = 0; n < 40; n++) begin
                    if (bus.o_drop) n_drop++;
                    if (bus.o_val) begin
                        seen = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
                if (!seen) n_miss++;
                if ({bus.o_carry, bus.o_dat} !== model(cur)) begin
                    n_bad++;
                    if (n_bad <= 3) check("b2b_res", {bus.o_carry, bus.o_dat}, model(cur));
                end
                if (i < 99) begin
                    for (int k = 0; k < NW; k++) cur[k] = 17'($urandom & 32'h1FFFF);
                    bus.i_dat = cur;
                    bus.i_val = 1'b1;
                end
            end
            repeat (3) begin
                @(negedge clk);
                if (bus.o_drop) n_drop++;
            end
            check("b2b_bad",  66'(n_bad), 66'd0);
            check("b2b_miss", 66'(n_miss), 66'd0);
            check("b2b_drop", 66'(n_drop), 66'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
